// File: rtl/eth_pcs_block_lock.sv
// 10GBASE-R RX block-lock state machine.
// Examines each 2-bit sync header from the gearbox, slips the gearbox one bit
// at a time until headers line up, and declares block lock after a clean
// window of SH_CNT_MAX valid headers. Loses lock when SH_INVLD_MAX invalid
// headers arrive within one window.
module eth_pcs_block_lock #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_HOLD    = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_en,
  input  logic       i_hdr_valid,
  input  logic [1:0] i_hdr,
  output logic       o_slip,
  output logic       o_block_lock,
  output logic       o_hdr_err,
  output logic [4:0] o_sh_invld_cnt
);

  localparam logic [1:0] ST_RESET_CNT = 2'd0;
  localparam logic [1:0] ST_TEST      = 2'd1;
  localparam logic [1:0] ST_SLIP      = 2'd2;

  localparam logic [6:0] SH_CNT_MAX_C   = 7'(SH_CNT_MAX);
  localparam logic [4:0] SH_INVLD_MAX_C = 5'(SH_INVLD_MAX);
  localparam logic [3:0] SLIP_HOLD_C    = 4'(SLIP_HOLD);

  logic [1:0] state_q, state_d;
  logic [6:0] sh_cnt_q, sh_cnt_d;
  logic [4:0] sh_invld_cnt_q, sh_invld_cnt_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       block_lock_q, block_lock_d;
  logic       slip_q, slip_d;
  logic       hdr_err_q, hdr_err_d;

  logic       hdr_event;
  logic       sh_valid;
  logic [6:0] sh_cnt_inc;
  logic [4:0] sh_invld_cnt_inc;

  assign hdr_event = i_clk_en & i_hdr_valid;
  assign sh_valid  = (i_hdr == 2'b01) | (i_hdr == 2'b10);

  // Saturating post-increment values used by the window decisions.
  assign sh_cnt_inc = (sh_cnt_q == SH_CNT_MAX_C) ? sh_cnt_q : sh_cnt_q + 7'd1;
  assign sh_invld_cnt_inc = (sh_valid || sh_invld_cnt_q == SH_INVLD_MAX_C)
                            ? sh_invld_cnt_q : sh_invld_cnt_q + 5'd1;

  // Next-state logic: header examination in TEST, event countdown in SLIP.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    block_lock_d   = block_lock_q;
    slip_d         = 1'b0;
    hdr_err_d      = 1'b0;

    case (state_q)
      // RESET_CNT examines a header arriving in its cycle exactly as TEST
      // would (counters are already zero), so no header is lost after reset.
      ST_RESET_CNT, ST_TEST: begin
        state_d = ST_TEST;
        if (hdr_event) begin
          sh_cnt_d       = sh_cnt_inc;
          sh_invld_cnt_d = sh_invld_cnt_inc;
          hdr_err_d      = ~sh_valid;
          if (!sh_valid && (!block_lock_q || sh_invld_cnt_inc == SH_INVLD_MAX_C)) begin
            // Unlocked and misaligned, or too many errors in this window.
            block_lock_d   = 1'b0;
            slip_d         = 1'b1;
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
            hold_cnt_d     = SLIP_HOLD_C;
            state_d        = ST_SLIP;
          end else if (sh_cnt_inc == SH_CNT_MAX_C) begin
            // Window complete: a clean window grants lock; otherwise keep lock.
            if (sh_invld_cnt_inc == 5'd0) block_lock_d = 1'b1;
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
          end
        end
      end

      // Discard header events while the gearbox settles on its new alignment.
      ST_SLIP: begin
        if (hdr_event) begin
          if (hold_cnt_q <= 4'd1) begin
            hold_cnt_d = '0;
            state_d    = ST_TEST;
          end else begin
            hold_cnt_d = hold_cnt_q - 4'd1;
          end
        end
      end

      default: state_d = ST_RESET_CNT;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!i_reset) begin
      state_q        <= ST_RESET_CNT;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      hold_cnt_q     <= '0;
      block_lock_q   <= 1'b0;
      slip_q         <= 1'b0;
      hdr_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      block_lock_q   <= block_lock_d;
      slip_q         <= slip_d;
      hdr_err_q      <= hdr_err_d;
    end
  end

  assign o_slip         = slip_q;
  assign o_block_lock   = block_lock_q;
  assign o_hdr_err      = hdr_err_q;
  assign o_sh_invld_cnt = sh_invld_cnt_q;

endmodule

// File: tb/tb_eth_pcs_block_lock.sv
// Scoreboard bench for eth_pcs_block_lock: stimulus drives inputs and pushes
// the expected post-edge outputs from a behavioural model; a monitor pops and
// compares after every clock edge.
module tb_eth_pcs_block_lock;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_clk_en = 1'b0;
  logic       i_hdr_valid = 1'b0;
  logic [1:0] i_hdr = 2'b00;
  logic       o_slip, o_block_lock, o_hdr_err;
  logic [4:0] o_sh_invld_cnt;

  always #5 clk = ~clk;

  eth_pcs_block_lock dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_clk_en       (i_clk_en),
    .i_hdr_valid    (i_hdr_valid),
    .i_hdr          (i_hdr),
    .o_slip         (o_slip),
    .o_block_lock   (o_block_lock),
    .o_hdr_err      (o_hdr_err),
    .o_sh_invld_cnt (o_sh_invld_cnt)
  );

  typedef struct packed {
    logic       lock;
    logic       slip;
    logic       err;
    logic [4:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle_no = 0;

  // Reference model: a window tally and a count of headers still to ignore.
  bit m_locked = 0;
  int m_ignore = 0;
  int m_seen   = 0;
  int m_bad    = 0;

  function automatic exp_t model(input logic rn, input logic ev, input logic [1:0] h);
    exp_t e;
    bit bad;
    e = '0;
    if (!rn) begin
      m_locked = 0; m_ignore = 0; m_seen = 0; m_bad = 0;
    end else if (ev) begin
      if (m_ignore > 0) begin
        m_ignore--;
      end else begin
        bad = (h == 2'b00) || (h == 2'b11);
        m_seen++;
        if (bad) m_bad++;
        e.err = bad;
        if (bad && (!m_locked || m_bad == 16)) begin
          m_locked = 0; e.slip = 1; m_seen = 0; m_bad = 0; m_ignore = 4;
        end else if (m_seen == 64) begin
          if (m_bad == 0) m_locked = 1;
          m_seen = 0; m_bad = 0;
        end
      end
    end
    e.lock = m_locked;
    e.cnt  = 5'(m_bad);
    return e;
  endfunction

  task automatic step(input logic rn, input logic en, input logic hv, input logic [1:0] h);
    @(negedge clk);
    i_reset = rn; i_clk_en = en; i_hdr_valid = hv; i_hdr = h;
    exp_q.push_back(model(rn, en & hv, h));
  endtask

  // One header event followed by one idle cycle (i_clk_en toggling).
  task automatic ev(input logic [1:0] h);
    step(1'b1, 1'b1, 1'b1, h);
    step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 2'b00);
  endtask

  task automatic valid_run(input int n);
    for (int i = 0; i < n; i++) ev($urandom_range(0, 1) ? 2'b01 : 2'b10);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cycle_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (o_block_lock !== e.lock || o_slip !== e.slip ||
          o_hdr_err !== e.err || o_sh_invld_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got lock=%b slip=%b err=%b cnt=%0d, expected lock=%b slip=%b err=%b cnt=%0d",
                 cycle_no, o_block_lock, o_slip, o_hdr_err, o_sh_invld_cnt,
                 e.lock, e.slip, e.err, e.cnt);
      end
    end
  end

  initial begin
    // Clean lock after reset with toggling clock enable.
    do_reset(3);
    valid_run(64);

    // Unlocked slip and hold-off: fifth event after slip is examined again.
    do_reset(1);
    valid_run(10);
    ev(2'b00);
    for (int i = 0; i < 4; i++) ev(2'b11);
    ev(2'b11);
    for (int i = 0; i < 4; i++) ev(2'b00);
    valid_run(64);

    // Locked window with 15 invalid headers keeps lock.
    for (int i = 0; i < 64; i++) ev((i % 4 == 0 && i < 60) ? 2'b11 : 2'b01);

    // 16 invalid headers early in a window: lock lost and slip.
    for (int i = 0; i < 16; i++) ev(2'b11);
    for (int i = 0; i < 4; i++) ev(2'b00);
    valid_run(64);

    // 16th invalid header lands on the 64th event of the window.
    for (int i = 0; i < 64; i++) ev(i < 48 ? 2'b10 : 2'b11);
    for (int i = 0; i < 4; i++) ev(2'b11);
    valid_run(64);

    // Header valid without clock enable: nothing moves.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b1, 2'b00);

    // Mid-window reset while locked with 5 invalid headers counted.
    for (int i = 0; i < 10; i++) ev(i % 2 ? 2'b01 : 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    valid_run(64);

    // Randomised traffic, mostly valid headers, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] h;
      h = ($urandom_range(0, 99) < 93) ? 2'($urandom_range(1, 2))
                                       : ($urandom_range(0, 1) ? 2'b11 : 2'b00);
      step(($urandom_range(0, 999) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), h);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_pcs_block_lock.md
Name: eth_pcs_block_lock

Overview:
- RX 10GBASE-R block-synchronisation state machine, per IEEE 802.3 Clause 49 lock_state.
- Sits between the RX gearbox and the RX descrambler (eth_pcs_scrambler with SCR_MODE=1).
- Examines each 2-bit sync header delivered by the gearbox, commands the gearbox to slip by one bit until alignment is found, and declares block lock.
- o_block_lock qualifies the descrambler clock enable and the decoder downstream.

Parameters:
- SH_CNT_MAX, 64: sync headers per test window.
- SH_INVLD_MAX, 16: invalid headers within one window that force loss of lock.
- SLIP_HOLD, 4: header events discarded after each slip while the gearbox re-aligns (1..15).

Ports:
- i_clk  input  1  PCS RX clock.
- i_reset  input  1  synchronous active-low reset.
- i_clk_en  input  1  gearbox output-valid; nothing advances when low.
- i_hdr_valid  input  1  current word carries a sync header (one word in two on the 32-bit path); qualified by i_clk_en.
- i_hdr  input  2  sync header bits as received.
- o_slip  output  1  one-cycle pulse; gearbox shifts its alignment by one bit.
- o_block_lock  output  1  block lock achieved.
- o_hdr_err  output  1  one-cycle pulse per examined header that is invalid (feeds the BER monitor).
- o_sh_invld_cnt  output  5  invalid-header count in the current window (status).

Behaviour:
- Header event: i_clk_en & i_hdr_valid in a cycle. All other cycles hold all state. o_slip and o_hdr_err are low in non-event cycles.
- Header validity: sh_valid = (i_hdr == 2'b01) | (i_hdr == 2'b10). Codes 00 and 11 are invalid.
- Reset (i_reset==0 at a clock edge):
  - state=RESET_CNT, sh_cnt=0, sh_invld_cnt=0, hold_cnt=0.
  - o_block_lock=0, o_slip=0, o_hdr_err=0, o_sh_invld_cnt=0.
  - Reset overrides any event in the same cycle, including mid-window and mid-slip-hold.
- Counters:
  - sh_cnt is 7 bits and counts 0..SH_CNT_MAX.
  - sh_invld_cnt is 5 bits and counts 0..SH_INVLD_MAX.
  - Both counters saturate and never wrap; they reset only as described below.
- State TEST (entered from RESET_CNT on the next clock, with counters zero). On each event:
  - sh_cnt+1 always. If invalid: sh_invld_cnt+1 and o_hdr_err=1 (registered, high the cycle after the event edge).
  - Decisions use the post-increment values, in this priority order:
    1. Invalid and o_block_lock==0 -> SLIP.
    2. Invalid and sh_invld_cnt==SH_INVLD_MAX -> o_block_lock<=0, SLIP.
    3. sh_cnt==SH_CNT_MAX and sh_invld_cnt==0 -> o_block_lock<=1, counters<=0, stay TEST.
    4. sh_cnt==SH_CNT_MAX otherwise -> counters<=0, stay TEST (lock unchanged).
    5. Else stay TEST.
- Lock latency: o_block_lock is high in the cycle after the edge that samples the 64th consecutive valid header.
- State SLIP:
  - Entry: o_slip=1 for exactly one cycle (the cycle after the decision edge), counters<=0, hold_cnt<=SLIP_HOLD.
  - Each subsequent event decrements hold_cnt; the header is not examined and o_hdr_err stays 0.
  - When hold_cnt reaches 0 -> TEST with counters zero.
  - A second slip can never be issued before SLIP_HOLD events have passed.
- Window boundary: the same event can complete the window and carry the 16th invalid header. Rule 2 wins: lock drops and SLIP is taken.
- o_sh_invld_cnt mirrors sh_invld_cnt as a register and reads 0 after a window reset or slip.

Test Plan:
- Reset low 3 cycles, then 64 events with i_hdr=2'b01 (i_clk_en toggling 1/0) -> o_block_lock=0 through the 63rd event; 1 in the cycle after the 64th; no o_slip ever.
- Unlocked, 10 valid headers then i_hdr=2'b00 -> o_hdr_err and o_slip each high exactly 1 cycle. The next 4 events with i_hdr=2'b11 produce no o_hdr_err and no slip. The 5th event is examined again.
- Locked; window of 64 events with 15 invalid (2'b11) spread evenly -> o_block_lock stays 1; o_sh_invld_cnt reaches 15, then reads 0 after the 64th event.
- Locked; 16 invalid headers within one window -> o_block_lock falls and o_slip pulses, both in the cycle after the 16th invalid event. Repeat with the 16th invalid header as the 64th event -> same result.
- i_hdr_valid=1 with i_clk_en=0 for 100 cycles carrying 2'b00 -> no state change, no pulses, counters unchanged.
- Locked mid-window with o_sh_invld_cnt=5, drive i_reset=0 one cycle -> next cycle o_block_lock=0, o_sh_invld_cnt=0, o_slip=0; a fresh 64-valid window relocks.
